// File: rtl/defines.sv
// Shared encoder definitions: data width, immediate format selector and
// the base opcodes produced by the self-test program loader.
package defines;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] OP     = 7'h33;

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: scatters the immediate into the field layout of the
// selected format and flags immediates that the format cannot represent.
module instr_packer
    import defines::*;
(
    input  logic [2:0]            fmt_i,
    input  logic [6:0]            opcode_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  legal_o
);

    imm_fmt_e fmt;
    logic     fitsI;
    logic     fitsB;
    logic     fitsJ;

    assign fmt = imm_fmt_e'(fmt_i);

    // Each range check asks whether the upper bits are pure sign extension.
    assign fitsI = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign fitsB = ((&imm_i[31:12]) || !(|imm_i[31:12])) && !imm_i[0];
    assign fitsJ = ((&imm_i[31:20]) || !(|imm_i[31:20])) && !imm_i[0];

    always_comb begin
        instr_o = '0;
        legal_o = 1'b0;
        case (fmt)
            FMT_R: begin
                instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                legal_o = 1'b1;
            end
            FMT_I: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                legal_o = fitsI;
            end
            FMT_S: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                legal_o = fitsI;
            end
            FMT_B: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
                legal_o = fitsB;
            end
            FMT_U: begin
                instr_o = {imm_i[31:12], rd_i, opcode_i};
                legal_o = (imm_i[11:0] == 12'h000);
            end
            FMT_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                legal_o = fitsJ;
            end
            default: begin
                instr_o = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts decoded fields over valid/ready,
// emits packed words with sequential byte addresses and counts illegal requests.
module instr_encoder #(
    parameter int DATA_WIDTH = defines::DATA_WIDTH,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            fmt_i,
    input  logic [6:0]            opcode_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  err_o,
    output logic [7:0]            err_cnt_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic [DATA_WIDTH-1:0] packedWord;
    logic                  legal;
    logic                  accept;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] instrAddr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  err_q;
    logic [7:0]            errCnt_q;

    instr_packer u_packer (
        .fmt_i    (fmt_i),
        .opcode_i (opcode_i),
        .rd_i     (rd_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .imm_i    (imm_i),
        .instr_o  (packedWord),
        .legal_o  (legal)
    );

    assign req_ready_o = !clear_i && (!valid_q || instr_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign addr_d      = addr_q + ADDR_WIDTH'(4);

    // Single output slot; a legal accept overwrites it in the same cycle it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            instr_q     <= '0;
            instrAddr_q <= BASE;
            addr_q      <= BASE;
            err_q       <= 1'b0;
            errCnt_q    <= 8'd0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            addr_q  <= BASE;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            if (accept && !legal && (errCnt_q != 8'hFF)) begin
                errCnt_q <= errCnt_q + 8'd1;
            end
            if (accept && legal) begin
                valid_q     <= 1'b1;
                instr_q     <= packedWord;
                instrAddr_q <= addr_q;
                addr_q      <= addr_d;
            end else if (instr_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_addr_o  = instrAddr_q;
    assign err_o         = err_q;
    assign err_cnt_o     = errCnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder; expected words are checked
// by decoding the emitted instruction back into fields and immediate.
module tb_instr_encoder;

    localparam int AW   = 12;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  fmt_i = '0;
    logic [6:0]  opcode_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [31:0] imm_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [AW-1:0] instr_addr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int checkCount = 0;
    int errorCount = 0;

    bit          mValid;
    int          mFmt;
    logic [6:0]  mOp;
    logic [4:0]  mRd, mRs1, mRs2;
    logic [2:0]  mF3;
    logic [6:0]  mF7;
    logic [31:0] mImm;
    int          mAddr;
    int          mCounter;
    bit          mErr;
    int          mErrCnt;

    instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .fmt_i         (fmt_i),
        .opcode_i      (opcode_i),
        .rd_i          (rd_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .imm_i         (imm_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .err_o         (err_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Legality stated as numeric ranges of the signed immediate.
    function automatic bit modelLegal(input int fmt, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (fmt)
            0: return 1'b1;
            1, 2: return (s >= -2048) && (s <= 2047);
            3: return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            4: return (imm % 32'd4096) == 32'd0;
            5: return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        mValid   = 1'b0;
        mCounter = BASE;
        mAddr    = BASE;
        mErr     = 1'b0;
        mErrCnt  = 0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_valid", 32'(instr_valid_o), 32'd0);
        checkOutput("rst_instr", instr_o, 32'd0);
        checkOutput("rst_addr", 32'(instr_addr_o), 32'(BASE));
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_errcnt", 32'(err_cnt_o), 32'd0);
        checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
    endtask

    // Decode the emitted word the way a decoder would and compare every field.
    task automatic checkWord();
        logic [31:0] w;
        logic [31:0] dImm;
        w = instr_o;
        checkOutput("opcode", 32'(w[6:0]), 32'(mOp));
        case (mFmt)
            0: begin
                checkOutput("R_rd", 32'(w[11:7]), 32'(mRd));
                checkOutput("R_f3", 32'(w[14:12]), 32'(mF3));
                checkOutput("R_rs1", 32'(w[19:15]), 32'(mRs1));
                checkOutput("R_rs2", 32'(w[24:20]), 32'(mRs2));
                checkOutput("R_f7", 32'(w[31:25]), 32'(mF7));
            end
            1: begin
                dImm = {{20{w[31]}}, w[31:20]};
                checkOutput("I_rd", 32'(w[11:7]), 32'(mRd));
                checkOutput("I_f3", 32'(w[14:12]), 32'(mF3));
                checkOutput("I_rs1", 32'(w[19:15]), 32'(mRs1));
                checkOutput("I_imm", dImm, mImm);
            end
            2: begin
                dImm = {{20{w[31]}}, w[31:25], w[11:7]};
                checkOutput("S_f3", 32'(w[14:12]), 32'(mF3));
                checkOutput("S_rs1", 32'(w[19:15]), 32'(mRs1));
                checkOutput("S_rs2", 32'(w[24:20]), 32'(mRs2));
                checkOutput("S_imm", dImm, mImm);
            end
            3: begin
                dImm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                checkOutput("B_f3", 32'(w[14:12]), 32'(mF3));
                checkOutput("B_rs1", 32'(w[19:15]), 32'(mRs1));
                checkOutput("B_rs2", 32'(w[24:20]), 32'(mRs2));
                checkOutput("B_imm", dImm, mImm);
            end
            4: begin
                dImm = {w[31:12], 12'h000};
                checkOutput("U_rd", 32'(w[11:7]), 32'(mRd));
                checkOutput("U_imm", dImm, mImm);
            end
            default: begin
                dImm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                checkOutput("J_rd", 32'(w[11:7]), 32'(mRd));
                checkOutput("J_imm", dImm, mImm);
            end
        endcase
    endtask

    // One clock of stimulus: drive, check ready, clock, advance model, check outputs.
    task automatic applyStimulus(input bit v, input int fmt, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm,
                                 input bit rdy, input bit clr);
        bit expReady;
        bit accept;
        bit legal;
        req_valid_i   = v;
        fmt_i         = 3'(fmt);
        opcode_i      = op;
        rd_i          = rd;
        rs1_i         = rs1;
        rs2_i         = rs2;
        funct3_i      = f3;
        funct7_i      = f7;
        imm_i         = imm;
        instr_ready_i = rdy;
        clear_i       = clr;
        #1;
        expReady = !clr && (!mValid || rdy);
        checkOutput("req_ready", 32'(req_ready_o), 32'(expReady));
        accept = v && expReady;
        legal  = modelLegal(fmt, imm);
        @(posedge clk);
        #1;
        if (clr) begin
            mValid   = 1'b0;
            mCounter = BASE;
            mErr     = 1'b0;
        end else begin
            mErr = accept && !legal;
            if (mErr && mErrCnt < 255) mErrCnt++;
            if (accept && legal) begin
                mValid = 1'b1;
                mFmt = fmt; mOp = op; mRd = rd; mRs1 = rs1; mRs2 = rs2;
                mF3 = f3; mF7 = f7; mImm = imm;
                mAddr = mCounter;
                mCounter = (mCounter + 4) % (1 << AW);
            end else if (rdy) begin
                mValid = 1'b0;
            end
        end
        checkOutput("valid", 32'(instr_valid_o), 32'(mValid));
        checkOutput("err", 32'(err_o), 32'(mErr));
        checkOutput("err_cnt", 32'(err_cnt_o), 32'(mErrCnt));
        if (mValid) begin
            checkOutput("addr", 32'(instr_addr_o), 32'(mAddr));
            checkWord();
        end
    endtask

    function automatic logic [31:0] randImm();
        int r;
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: begin r = int'($urandom_range(0, 8191)) - 4096; return 32'(r); end
            2: begin r = int'($urandom_range(0, 4194303)) - 2097152; return 32'(r); end
            3: begin r = int'($urandom); if ($urandom_range(0, 3) != 0) r = r & 32'hFFFFF000; return 32'(r); end
            default: begin r = (int'($urandom_range(0, 4095)) - 2048) * 2; return 32'(r); end
        endcase
    endfunction

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetState();
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 1, 7'h13, 5'd10, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1, 0);
        checkOutput("addi_word", instr_o, 32'hFFF08513);
        checkOutput("addi_addr", 32'(instr_addr_o), 32'h000);
        applyStimulus(1, 2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, 1, 0);
        checkOutput("sw_word", instr_o, 32'h0020A623);
        checkOutput("sw_addr", 32'(instr_addr_o), 32'h004);
        applyStimulus(1, 3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1, 0);
        checkOutput("beq_word", instr_o, 32'hFE208EE3);
        checkOutput("beq_addr", 32'(instr_addr_o), 32'h008);
        applyStimulus(1, 4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 0);
        checkOutput("lui_word", instr_o, 32'h12345537);
        applyStimulus(1, 5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000100, 1, 0);
        checkOutput("jal_fwd", instr_o, 32'h1000006F);
        applyStimulus(1, 5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1, 0);
        checkOutput("jal_back", instr_o, 32'hFFDFF06F);

        applyStimulus(1, 1, 7'h13, 5'd10, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 0);
        applyStimulus(1, 3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1, 0);
        applyStimulus(1, 4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1, 0);
        checkOutput("illegal_cnt", 32'(err_cnt_o), 32'd3);
        applyStimulus(1, 0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'hDEADBEEF, 1, 0);
        checkOutput("after_err_addr", 32'(instr_addr_o), 32'h018);

        applyStimulus(1, 1, 7'h13, 5'd7, 5'd8, 5'd0, 3'd1, 7'd0, 32'd100, 1, 0);
        repeat (3) applyStimulus(1, 1, 7'h13, 5'd9, 5'd9, 5'd0, 3'd1, 7'd0, 32'd5, 0, 0);
        checkOutput("bp_hold_addr", 32'(instr_addr_o), 32'h01C);
        applyStimulus(1, 1, 7'h13, 5'd9, 5'd9, 5'd0, 3'd1, 7'd0, 32'd5, 1, 0);
        checkOutput("bp_release_addr", 32'(instr_addr_o), 32'h020);

        applyStimulus(1, 0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1, 1);
        applyStimulus(1, 0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1, 0);
        checkOutput("clear_addr", 32'(instr_addr_o), 32'(BASE));

        for (int i = 0; i < 400; i++) begin
            int fmt;
            fmt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            applyStimulus($urandom_range(0, 9) < 7, fmt, 7'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 3'($urandom), 7'($urandom), randImm(),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        applyStimulus(0, 0, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1, 1);
        for (int i = 0; i < 1023; i++)
            applyStimulus(1, 0, 7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 0);
        applyStimulus(1, 0, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 0);
        checkOutput("wrap_last", 32'(instr_addr_o), 32'hFFC);
        applyStimulus(1, 0, 7'h33, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 0);
        checkOutput("wrap_zero", 32'(instr_addr_o), 32'h000);

        for (int i = 0; i < 260; i++)
            applyStimulus(1, 7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1, 0);
        checkOutput("err_sat", 32'(err_cnt_o), 32'd255);

        applyStimulus(1, 1, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1, 0, 0);
        req_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        modelReset();
        checkResetState();
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 1, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1, 1, 0);
        checkOutput("post_rst_addr", 32'(instr_addr_o), 32'(BASE));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
